// File: rtl/bcd_binary_converter.sv
// ---------------------------------------------------------------------------
// bcd_binary_converter
//
// Sequential 3-digit BCD to 8-bit binary converter using reverse double-dabble.
// An accepted request loads {hundreds, tens, ones} into an 18-bit work register
// {bcd[9:0], bin[7:0]}. The register shifts right one bit per clock, and any
// BCD nibble that reads >= 8 after a shift is reduced by 3. After 8 shifts the
// bin field holds the binary value. Bad inputs finish on the accepting edge.
//
// Optional build macro:
//   BCD2BIN_CLAMP_EN - values 256..299 with valid digits complete immediately
//                      with binary=8'hFF and error=0 instead of erroring.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  conversion request, sampled only while busy=0
//   hundreds in   2  BCD hundreds digit
//   tens     in   4  BCD tens digit
//   ones     in   4  BCD ones digit
//   binary   out  8  result, held between conversions
//   busy     out  1  high while shifting
//   done     out  1  one-cycle completion pulse
//   error    out  1  input invalid / out of range, held with binary
// ---------------------------------------------------------------------------
module bcd_binary_converter #(
    parameter logic [7:0] ERROR_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [7:0] binary,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] work_q, work_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  binary_q, binary_d;
    logic        error_q, error_d;

    logic [17:0] shifted;
    logic [17:0] corrected;
    logic        digit_bad;
    logic        over_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        digit_bad  = (tens > 4'd9) || (ones > 4'd9);
        over_range = (hundreds == 2'd3) ||
                     ((hundreds == 2'd2) &&
                      ((tens > 4'd5) || ((tens == 4'd5) && (ones > 4'd5))));

        // The hundreds field is only 2 bits and receives a zero from the top,
        // so it never reaches 8 and needs no correction.
        shifted   = work_q >> 1;
        corrected = shifted;
        if (shifted[15:12] >= 4'd8) begin
            corrected[15:12] = shifted[15:12] - 4'd3;
        end
        if (shifted[11:8] >= 4'd8) begin
            corrected[11:8] = shifted[11:8] - 4'd3;
        end

        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        error_d  = error_q;

        case (state_q)
            ST_SHIFT: begin
                work_d = corrected;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    binary_d = corrected[7:0];
                    state_d  = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE otherwise falls back to IDLE.
                state_d = ST_IDLE;
                if (start) begin
`ifdef BCD2BIN_CLAMP_EN
                    if (digit_bad || (hundreds == 2'd3)) begin
                        state_d  = ST_DONE;
                        binary_d = ERROR_VALUE;
                        error_d  = 1'b1;
                    end else if (over_range) begin
                        state_d  = ST_DONE;
                        binary_d = 8'hFF;
                        error_d  = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                        work_d  = {hundreds, tens, ones, 8'h00};
                        cnt_d   = '0;
                        error_d = 1'b0;
                    end
`else
                    if (digit_bad || over_range) begin
                        state_d  = ST_DONE;
                        binary_d = ERROR_VALUE;
                        error_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        work_d  = {hundreds, tens, ones, 8'h00};
                        cnt_d   = '0;
                        error_d = 1'b0;
                    end
`endif
                end
            end
        endcase
    end

    assign binary = binary_q;
    assign error  = error_q;
    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_binary_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_binary_converter
//
// Scoreboard bench: the driver pushes the expected {binary, error, done cycle}
// for every accepted request, and an independent monitor pops and compares on
// every done pulse. Expected values come from decimal arithmetic on the digits.
// ---------------------------------------------------------------------------
module tb_bcd_binary_converter;

    localparam logic [7:0] ERR_VAL = 8'hEE;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] binary;
    logic       busy;
    logic       done;
    logic       error;

    typedef struct {
        logic [7:0] b;
        logic       e;
        int         due;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    bcd_binary_converter #(.ERROR_VALUE(ERR_VAL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .binary   (binary),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: plain decimal value and range rules.
    function automatic void model(input int h, input int t, input int o,
                                  output logic [7:0] b, output logic e,
                                  output int lat);
        int v;
        v = h * 100 + t * 10 + o;
        if (t > 9 || o > 9 || h == 3) begin
            b = ERR_VAL; e = 1'b1; lat = 1;
        end else if (v > 255) begin
`ifdef BCD2BIN_CLAMP_EN
            b = 8'hFF; e = 1'b0; lat = 1;
`else
            b = ERR_VAL; e = 1'b1; lat = 1;
`endif
        end else begin
            b = v[7:0]; e = 1'b0; lat = 9;
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    x = q.pop_front();
                    check("binary", int'(binary), int'(x.b));
                    check("error", int'(error), int'(x.e));
                    check("done_cycle", cyc, x.due);
                end
            end
        end
    end

    // Issue one request at a negedge where the DUT can accept it.
    task automatic issue(input int h, input int t, input int o);
        exp_t       x;
        int         lat;
        int         n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("wait_not_busy_timeout", 1, 0);
        hundreds = 2'(h);
        tens     = 4'(t);
        ones     = 4'(o);
        start    = 1'b1;
        model(h, t, o, x.b, x.e, lat);
        x.due = cyc + lat;
        q.push_back(x);
        @(negedge clk);
        start    = 1'b0;
        hundreds = 2'($urandom_range(0, 3));
        tens     = 4'($urandom_range(0, 15));
        ones     = 4'($urandom_range(0, 15));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 1, 0);
    endtask

    initial begin
        int bc;
        rst_n    = 1'b0;
        start    = 1'b0;
        hundreds = '0;
        tens     = '0;
        ones     = '0;
        repeat (3) @(negedge clk);
        check("reset_binary", int'(binary), 0);
        check("reset_busy",   int'(busy),   0);
        check("reset_done",   int'(done),   0);
        check("reset_error",  int'(error),  0);
        rst_n = 1'b1;
        @(negedge clk);

        // 255 through the full shift path, busy for exactly 8 cycles.
        issue(2, 5, 5);
        bc = 0;
        for (int i = 0; i < 9; i++) begin
            if (busy) bc++;
            @(negedge clk);
        end
        check("busy_cycles_255", bc, 8);
        drain();

        // Back-to-back with the second start in the DONE cycle.
        issue(1, 3, 7);
        issue(0, 0, 0);
        drain();

        // Invalid digit and range edges.
        issue(0, 10, 4);
        issue(2, 5, 6);
        issue(3, 0, 0);
        issue(2, 6, 0);
        issue(2, 5, 5);
        drain();

        // Starts during a conversion are ignored.
        issue(0, 4, 2);
        @(negedge clk);
        hundreds = 2'd1; tens = 4'd9; ones = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        check("queue_empty_after_ignored", q.size(), 0);

        // Reset mid-conversion: immediate reset values, no done.
        issue(1, 9, 9);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_binary", int'(binary), 0);
        check("abort_busy",   int'(busy),   0);
        check("abort_done",   int'(done),   0);
        check("abort_error",  int'(error),  0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1, 9, 9);
        drain();

        // Randomized traffic, biased towards valid digits.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0)
                issue(int'($urandom_range(0, 2)), int'($urandom_range(0, 9)),
                      int'($urandom_range(0, 9)));
            else
                issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();
        check("queue_empty_final", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_binary_converter.md
Name: bcd_binary_converter

Overview:
- Sequential BCD-to-binary converter; the inverse of the existing binary-to-BCD path.
- Takes a 3-digit keypad/display value (hundreds 0-2, tens, ones) and produces an 8-bit binary value for ATM arithmetic (balance, withdrawal amount).
- Uses reverse double-dabble (shift right, subtract 3 from any digit >= 8), one shift per clock, with a start/done handshake.
- Sits between keypad digit entry and the account arithmetic datapath.

Parameters:
- ERROR_VALUE, 8'h00, value driven on binary when a conversion ends in error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only while busy=0.
- hundreds  input  2  BCD hundreds digit.
- tens  input  4  BCD tens digit.
- ones  input  4  BCD ones digit.
- binary  output  8  conversion result; held until the next accepted start.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse when binary/error are valid.
- error  output  1  high with done if the input was invalid; held with binary.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, binary=8'h00, busy=0, done=0, error=0, shift counter=0.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: done=1 for exactly one cycle, busy=0.
- Accept: start=1 at an edge while in IDLE or DONE captures {hundreds,tens,ones} into an 18-bit work register {bcd[9:0], bin[7:0]}, with bin=0, and validates it on the same edge.
  - Invalid digit: tens>9 or ones>9.
  - Out of range: value>255, i.e. hundreds=3; or hundreds=2 and tens>5; or hundreds=2, tens=5 and ones>5.
  - Invalid or out of range: next state DONE, binary=ERROR_VALUE, error=1. done is seen after that single edge (latency 1).
  - Valid: next state SHIFT, counter=0, error cleared.
- SHIFT, each edge:
  - Shift the work register right by 1.
  - In the shifted value, subtract 3 from the tens nibble if it is >= 8, and from the ones nibble if it is >= 8, independently and in the same cycle.
  - The 2-bit hundreds field needs no correction.
  - counter increments.
  - After the 8th shift (counter was 7): binary <= shifted bin, state=DONE.
- Valid latency: done is high in the cycle after the 9th rising edge counted from the accepting edge (1 load edge + 8 shift edges). The bcd field is zero at completion.
- DONE lasts one cycle, then IDLE. A start in the DONE cycle is accepted: back-to-back conversions are possible and done stays a single-cycle pulse per conversion.
- start while busy=1 is ignored entirely; inputs are not re-sampled.
- Input digits may change freely after the accepting edge.
- Between conversions, binary and error hold their last values. They update only at the completing edge, or at the accepting edge for the immediate-error path.
- rst_n low mid-conversion: immediately returns to the reset values. There is no done for the aborted conversion.

Optional Feature:
- Macro: BCD2BIN_CLAMP_EN.
- Defined: inputs with valid digits but value 256-299 complete immediately (latency 1) with binary=8'hFF and error=0.
- Invalid digits and hundreds=3 still report error with ERROR_VALUE.
- Undefined: every value >255 is an error as specified in Behaviour.

Test Plan:
- Reset, then start with h=2, t=5, o=5 -> busy high 8 cycles, done pulse after edge 9, binary=8'hFF, error=0.
- Back-to-back: h=1, t=3, o=7 then h=0, t=0, o=0 with start asserted in the DONE cycle -> binary=8'h89 then 8'h00, two distinct single-cycle done pulses.
- Invalid digit h=0, t=10, o=4 -> done after 1 edge, error=1, binary=ERROR_VALUE. Repeat with ERROR_VALUE=8'hEE -> binary=8'hEE.
- Range edge cases h=2, t=5, o=6:
  - Macro off -> error=1, latency 1.
  - Macro on -> binary=8'hFF, error=0.
  - h=2, t=5, o=5 in both builds -> 8'hFF via the full shift path.
- start pulsed at cycles 3 and 6 of a conversion of 042 -> both pulses ignored, one done, binary=8'h2A.
- rst_n driven low at shift 4 of a conversion of 199 -> outputs go to reset values asynchronously, no done. A fresh start of 199 after release -> binary=8'hC7.
